// File: rtl/fpu_conv_pkg.sv
// Shared constants, state encoding and width-derived helpers for the FPU conversion units.
package fpu_conv_pkg;

  localparam logic [1:0] RND_NE = 2'b00;
  localparam logic [1:0] RND_RZ = 2'b01;
  localparam logic [1:0] RND_RU = 2'b10;
  localparam logic [1:0] RND_RD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } conv_state_e;

  localparam int unsigned SAT_MAX_W = 128;

  function automatic int bias_of(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Saturation patterns are built wide and truncated to INT_W by the user.
  function automatic logic [SAT_MAX_W-1:0] smax_of(input int unsigned int_w);
    return {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - int_w + 1);
  endfunction

  function automatic logic [SAT_MAX_W-1:0] smin_of(input int unsigned int_w);
    return {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (int_w - 1);
  endfunction

endpackage

// File: rtl/fp2i_round.sv
// Combinational round-up decision for float->int conversion.
// All four modes only with FP2INT_FULL_ROUNDING_EN; otherwise always truncates.
module fp2i_round
  import fpu_conv_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [1:0] mode,
  output logic       increment
);

`ifdef FP2INT_FULL_ROUNDING_EN
  always_comb begin
    increment = 1'b0;
    case (mode)
      RND_NE:  increment = guard & (sticky | lsb);
      RND_RU:  increment = ~sign & (guard | sticky);
      RND_RD:  increment = sign & (guard | sticky);
      default: increment = 1'b0;
    endcase
  end
`else
  logic unused_round_in;
  assign unused_round_in = ^{sign, lsb, guard, sticky, mode};
  assign increment       = 1'b0;
`endif

endmodule

// File: rtl/fp2int_conv_iter.sv
// Iterative float->integer converter with valid/ready handshakes and SHIFT_STEP-bit shifter.
// Rounding modes beyond toward-zero require FP2INT_FULL_ROUNDING_EN.
module fp2int_conv_iter
  import fpu_conv_pkg::*;
#(
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 23,
  parameter int unsigned INT_W      = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic                   is_signed,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       result,
  output logic                   invalid,
  output logic                   inexact
);

  localparam int               BIAS  = bias_of(EXP_W);
  localparam int unsigned      CNT_W = $clog2(INT_W + MAN_W + 3);
  localparam logic [INT_W-1:0] SMAX  = INT_W'(smax_of(INT_W));
  localparam logic [INT_W-1:0] SMIN  = INT_W'(smin_of(INT_W));

  conv_state_e       state_q, state_d;
  logic              sign_q, sign_d, signed_q, signed_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MAN_W-1:0]  frac_q, frac_d;
  logic [1:0]        mode_q, mode_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              left_q, left_d, inv_q, inv_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [INT_W-1:0]  result_q, result_d;
  logic              invalid_q, invalid_d, inexact_q, inexact_d;

  logic              rnd_inc;
  int                e_val, c_val, k_val, lim_val;
  logic              exact_min, is_nan, ovf;
  logic [INT_W-1:0]  m_tmp, mag_out;
  logic              g_tmp, s_tmp;
  logic [CNT_W-1:0]  n_tmp;
  logic [INT_W:0]    sum;

  fp2i_round u_round (
    .sign      (sign_q),
    .lsb       (mag_q[0]),
    .guard     (guard_q),
    .sticky    (sticky_q),
    .mode      (mode_q),
    .increment (rnd_inc)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    signed_d    = signed_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
    mode_d      = mode_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    inv_d       = inv_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    e_val       = int'(exp_q) - BIAS;
    c_val       = e_val - int'(MAN_W);
    k_val       = 0;
    lim_val     = int'(INT_W) - (signed_q ? 1 : 0);
    exact_min   = signed_q && sign_q && (e_val == int'(INT_W) - 1) && (frac_q == '0);
    is_nan      = (&exp_q) && (frac_q != '0);
    m_tmp       = mag_q;
    g_tmp       = guard_q;
    s_tmp       = sticky_q;
    n_tmp       = cnt_q;
    sum         = {1'b0, mag_q} + (INT_W+1)'(rnd_inc);
    mag_out     = sum[INT_W-1:0];
    ovf         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          {sign_d, exp_d, frac_d} = a;
          signed_d   = is_signed;
          mode_d     = rnd_mode;
          in_ready_d = 1'b0;
          state_d    = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        mag_d    = INT_W'({|exp_q, frac_q});
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        inv_d    = 1'b0;
        if ((&exp_q) || ((e_val >= lim_val) && !exact_min)) begin
          inv_d   = 1'b1;
          state_d = ST_ROUND;
        end else begin
          left_d = (c_val > 0);
          k_val  = (c_val > 0) ? c_val : -c_val;
          if ((c_val < 0) && (k_val > int'(MAN_W) + 2)) k_val = int'(MAN_W) + 2;
          cnt_d   = CNT_W'(k_val);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Unrolled single-bit steps; a zero count still spends one cycle here.
        for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
          if (n_tmp != '0) begin
            if (left_q) begin
              m_tmp = m_tmp << 1;
            end else begin
              s_tmp = s_tmp | g_tmp;
              g_tmp = m_tmp[0];
              m_tmp = m_tmp >> 1;
            end
            n_tmp = n_tmp - CNT_W'(1);
          end
        end
        mag_d    = m_tmp;
        guard_d  = g_tmp;
        sticky_d = s_tmp;
        cnt_d    = n_tmp;
        if (n_tmp == '0) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (signed_q) ovf = sign_q ? (sum > {1'b0, SMIN}) : (sum > {1'b0, SMAX});
        else          ovf = sign_q ? (sum != '0) : sum[INT_W];
        if (inv_q || ovf) begin
          invalid_d = 1'b1;
          inexact_d = 1'b0;
          if (is_nan || !sign_q) result_d = signed_q ? SMAX : '1;
          else                   result_d = signed_q ? SMIN : '0;
        end else begin
          invalid_d = 1'b0;
          inexact_d = guard_q | sticky_q;
          result_d  = sign_q ? (~mag_out + INT_W'(1)) : mag_out;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      signed_q    <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      mode_q      <= RND_NE;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      signed_q    <= signed_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      mode_q      <= mode_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp2int_conv_iter.sv
// Directed scoreboard bench for fp2int_conv_iter (EXP_W=8, MAN_W=23, INT_W=32, SHIFT_STEP=4).
// Expectations follow FP2INT_FULL_ROUNDING_EN when defined.
module tb_fp2int_conv_iter;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, is_signed, out_ready;
  logic [1:0]  rnd_mode;
  logic [31:0] a;
  logic        in_ready, out_valid, invalid, inexact;
  logic [31:0] result;

  localparam logic [1:0] NE = 2'b00, RZ = 2'b01, RU = 2'b10, RD = 2'b11;
`ifdef FP2INT_FULL_ROUNDING_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  fp2int_conv_iter #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SHIFT_STEP(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .is_signed (is_signed),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input string tag, input logic [31:0] av, input logic sg, input logic [1:0] md,
                      input logic [31:0] res, input logic inv, input logic inx, input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.inv = inv; e.inx = inx; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    a = av; is_signed = sg; rnd_mode = md; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom(); is_signed = ~sg; rnd_mode = ~md;
  endtask

  task automatic collect();
    int   cyc;
    exp_t e;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check({e.tag, "/out_valid"}, {31'd0, out_valid}, 32'd1);
    check({e.tag, "/result"},    result,             e.res);
    check({e.tag, "/invalid"},   {31'd0, invalid},   {31'd0, e.inv});
    check({e.tag, "/inexact"},   {31'd0, inexact},   {31'd0, e.inx});
    check({e.tag, "/busy"},      {31'd0, in_ready},  32'd0);
    if (e.lat > 0) check({e.tag, "/latency"}, cyc, e.lat);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire/out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic convert(input string tag, input logic [31:0] av, input logic sg, input logic [1:0] md,
                         input logic [31:0] res, input logic inv, input logic inx, input int lat);
    send(tag, av, sg, md, res, inv, inx, lat);
    collect();
    retire();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; is_signed = 1'b0; rnd_mode = NE;
    repeat (2) @(negedge clk);
    check("reset/in_ready",  {31'd0, in_ready},  32'd1);
    check("reset/out_valid", {31'd0, out_valid}, 32'd0);
    check("reset/result",    result,             32'd0);
    check("reset/invalid",   {31'd0, invalid},   32'd0);
    check("reset/inexact",   {31'd0, inexact},   32'd0);
    reset_n = 1'b1;

    convert("pi_rz",      32'h40490FDB, 1'b1, RZ, 32'h00000003, 1'b0, 1'b1, 8);
    convert("rne_1p5",    32'h3FC00000, 1'b1, NE, FULL ? 32'd2 : 32'd1, 1'b0, 1'b1, 8);
    convert("rne_2p5",    32'h40200000, 1'b1, NE, 32'd2, 1'b0, 1'b1, 8);
    convert("rne_3p5",    32'h40600000, 1'b1, NE, FULL ? 32'd4 : 32'd3, 1'b0, 1'b1, 8);
    convert("s_min",      32'hCF000000, 1'b1, RZ, 32'h80000000, 1'b0, 1'b0, 4);
    convert("s_ovf",      32'h4F000000, 1'b1, RZ, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
    convert("s_nan",      32'h7FC00000, 1'b1, RZ, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
    convert("s_ninf",     32'hFF800000, 1'b1, RZ, 32'h80000000, 1'b1, 1'b0, 2);
    convert("u_neg_half", 32'hBF000000, 1'b0, RZ, 32'h00000000, 1'b0, 1'b1, 8);
    convert("u_neg_one",  32'hBF800000, 1'b0, RZ, 32'h00000000, 1'b1, 1'b0, 8);
    convert("u_ovf",      32'h4F800000, 1'b0, RZ, 32'hFFFFFFFF, 1'b1, 1'b0, 2);
    convert("u_nan",      32'h7FC00000, 1'b0, RZ, 32'hFFFFFFFF, 1'b1, 1'b0, 2);
    convert("u_big",      32'h4F7FFFFF, 1'b0, RZ, 32'hFFFFFF00, 1'b0, 1'b0, 4);
    convert("rd_neg1p5",  32'hBFC00000, 1'b1, RD, FULL ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b0, 1'b1, 8);
    convert("shift_c0",   32'h4B000000, 1'b1, RZ, 32'h00800000, 1'b0, 1'b0, 3);
    convert("shift_c1",   32'h4B800000, 1'b1, NE, 32'h01000000, 1'b0, 1'b0, 3);
    convert("zero",       32'h00000000, 1'b1, NE, 32'h00000000, 1'b0, 1'b0, 0);
    convert("denorm_ru",  32'h00000001, 1'b1, RU, FULL ? 32'd1 : 32'd0, 1'b0, 1'b1, 0);
    convert("ndenorm_rd", 32'h80000001, 1'b1, RD, FULL ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b1, 0);
    convert("ru_quarter", 32'h3E800000, 1'b1, RU, FULL ? 32'd1 : 32'd0, 1'b0, 1'b1, 9);

    // Stall with out_ready low while a competing operand is offered.
    send("stall", 32'h3FC00000, 1'b1, NE, FULL ? 32'd2 : 32'd1, 1'b0, 1'b1, 8);
    a = 32'h4F000000; is_signed = 1'b1; in_valid = 1'b1;
    collect();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall/result",    result,             FULL ? 32'd2 : 32'd1);
      check("stall/invalid",   {31'd0, invalid},   32'd0);
      check("stall/in_ready",  {31'd0, in_ready},  32'd0);
      check("stall/out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    retire();
    repeat (3) @(negedge clk);
    check("stall/ignored_in", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while the shifter is busy.
    send("reset_mid", 32'h40490FDB, 1'b1, RZ, 32'h00000003, 1'b0, 1'b1, 8);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid/in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_mid/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid/result",    result,             32'd0);
    check("rst_mid/invalid",   {31'd0, invalid},   32'd0);
    check("rst_mid/inexact",   {31'd0, inexact},   32'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid/no_output", {31'd0, out_valid}, 32'd0);

    convert("after_reset", 32'h40490FDB, 1'b1, RZ, 32'h00000003, 1'b0, 1'b1, 8);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
